// File: rtl/mips_avalon_master.sv
// mips_avalon_master
//   Avalon-MM master that converts single MIPS load/store requests into bus
//   transactions. One transaction outstanding at a time. Generates byte
//   enables, places store data on the proper lanes, and extracts and extends
//   load data from the addressed lanes.
//
//   Optional feature macro: MIPS_AVALON_MASTER_TIMEOUT_EN
//     When defined, a BUS access stalled by waitrequest for TIMEOUT_CYCLES
//     cycles is aborted and completed with resp_err = 1.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   req_valid / req_ready     CPU request handshake (ready only in IDLE)
//   req_write                 1 = store, 0 = load
//   req_addr, req_size        byte address; 00 byte, 01 half, 10 word
//   req_signed                sign-extend load result
//   req_wdata                 right-justified store data
//   resp_valid                one-cycle completion pulse
//   resp_rdata, resp_err      extended load data / misaligned-or-timeout flag
//   address, read, write      Avalon command (address is word aligned)
//   writedata, byteenable     lane-placed store data and lane enables
//   waitrequest, readdata     Avalon slave stall and read data
module mips_avalon_master #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic        waitrequest,
    input  logic [31:0] readdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    if (TIMEOUT_CYCLES == 0) begin : g_timeout_check
        $error("TIMEOUT_CYCLES must be nonzero");
    end

    state_t      state, state_n;

    // Access attributes kept for read-data extraction at completion.
    logic [1:0]  acc_lane, acc_lane_n;
    logic [1:0]  acc_size, acc_size_n;
    logic        acc_signed, acc_signed_n;

    logic        req_ready_n;
    logic        read_n, write_n;
    logic [31:0] address_n, writedata_n;
    logic [3:0]  byteenable_n;
    logic        resp_valid_n, resp_err_n;
    logic [31:0] resp_rdata_n;

    logic        timeout_hit;

    // Request decode: alignment, lane enables and lane-placed store data.
    logic        misaligned;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [4:0]  req_shift;

    always_comb begin
        req_shift  = {req_addr[1:0], 3'b000};
        misaligned = 1'b0;
        lane_be    = '0;
        lane_wdata = '0;
        case (req_size)
            2'b00: begin
                lane_be    = 4'b0001 << req_addr[1:0];
                lane_wdata = {24'h0, req_wdata[7:0]} << req_shift;
            end
            2'b01: begin
                misaligned = req_addr[0];
                lane_be    = 4'b0011 << req_addr[1:0];
                lane_wdata = {16'h0, req_wdata[15:0]} << req_shift;
            end
            2'b10: begin
                misaligned = (req_addr[1:0] != 2'b00);
                lane_be    = 4'b1111;
                lane_wdata = req_wdata;
            end
            default: misaligned = 1'b1;
        endcase
    end

    // Read-data extraction: shift the addressed lane down, then extend.
    logic [31:0] rd_shifted, rd_ext;

    always_comb begin
        rd_shifted = readdata >> {acc_lane, 3'b000};
        case (acc_size)
            2'b00:   rd_ext = {{24{acc_signed & rd_shifted[7]}}, rd_shifted[7:0]};
            2'b01:   rd_ext = {{16{acc_signed & rd_shifted[15]}}, rd_shifted[15:0]};
            default: rd_ext = rd_shifted;
        endcase
    end

`ifdef MIPS_AVALON_MASTER_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] stall_cnt;

    // Held at zero outside BUS, which is equivalent to clearing on BUS entry.
    always_ff @(posedge clk) begin
        if (rst || state != BUS) begin
            stall_cnt <= '0;
        end else if (waitrequest) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    // Fires on the stalled edge that brings the count to TIMEOUT_CYCLES.
    assign timeout_hit = waitrequest && (stall_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_n      = state;
        acc_lane_n   = acc_lane;
        acc_size_n   = acc_size;
        acc_signed_n = acc_signed;
        read_n       = read;
        write_n      = write;
        address_n    = address;
        writedata_n  = writedata;
        byteenable_n = byteenable;
        resp_valid_n = 1'b0;
        resp_err_n   = 1'b0;
        resp_rdata_n = '0;

        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    acc_lane_n   = req_addr[1:0];
                    acc_size_n   = req_size;
                    acc_signed_n = req_signed;
                    if (misaligned) begin
                        state_n      = RESP;
                        resp_valid_n = 1'b1;
                        resp_err_n   = 1'b1;
                    end else begin
                        state_n      = BUS;
                        read_n       = ~req_write;
                        write_n      = req_write;
                        address_n    = {req_addr[31:2], 2'b00};
                        byteenable_n = lane_be;
                        writedata_n  = req_write ? lane_wdata : '0;
                    end
                end
            end
            BUS: begin
                if (!waitrequest) begin
                    state_n      = RESP;
                    read_n       = 1'b0;
                    write_n      = 1'b0;
                    resp_valid_n = 1'b1;
                    resp_rdata_n = read ? rd_ext : '0;
                end else if (timeout_hit) begin
                    state_n      = RESP;
                    read_n       = 1'b0;
                    write_n      = 1'b0;
                    resp_valid_n = 1'b1;
                    resp_err_n   = 1'b1;
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                read_n  = 1'b0;
                write_n = 1'b0;
            end
        endcase

        req_ready_n = (state_n == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            acc_lane   <= '0;
            acc_size   <= '0;
            acc_signed <= 1'b0;
            req_ready  <= 1'b1;
            read       <= 1'b0;
            write      <= 1'b0;
            address    <= '0;
            writedata  <= '0;
            byteenable <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            state      <= state_n;
            acc_lane   <= acc_lane_n;
            acc_size   <= acc_size_n;
            acc_signed <= acc_signed_n;
            req_ready  <= req_ready_n;
            read       <= read_n;
            write      <= write_n;
            address    <= address_n;
            writedata  <= writedata_n;
            byteenable <= byteenable_n;
            resp_valid <= resp_valid_n;
            resp_err   <= resp_err_n;
            resp_rdata <= resp_rdata_n;
        end
    end

endmodule

// File: doc/mips_avalon_master.md
# mips_avalon_master

Avalon memory-mapped master that turns single MIPS CPU load/store requests into bus transactions for `mips_avalon_slave` and other Avalon responders. It sits between the CPU memory stage and the Avalon bus. It handles byte-enable generation, write-lane placement, read-lane extraction with sign or zero extension, and the `waitrequest` handshake. It allows one outstanding transaction.

## Interface
- `TIMEOUT_CYCLES`, 1024: maximum number of `waitrequest`-stalled cycles before abort. Used only with the timeout macro.
- `clk` in 1: clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: CPU request strobe.
- `req_ready` out 1: master can accept a request; high only in IDLE.
- `req_write` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address.
- `req_size` in 2: 00 = byte, 01 = half, 10 = word; 11 is treated as misaligned.
- `req_signed` in 1: sign-extend load result.
- `req_wdata` in 32: store data, right-justified.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: extended load data; 0 for stores and errors.
- `resp_err` out 1: misaligned access or timeout; qualified by `resp_valid`.
- `address` out 32: word-aligned byte address, `{req_addr[31:2],2'b00}`.
- `read` out 1: Avalon read.
- `write` out 1: Avalon write.
- `writedata` out 32: lane-placed store data.
- `byteenable` out 4: active lanes.
- `waitrequest` in 1: slave stall.
- `readdata` in 32: slave read data.

## Operation
- FSM states:
  - IDLE: request accepted when `req_valid && req_ready`. The request is registered. Next state is BUS if aligned, RESP with error if misaligned.
  - BUS: `read` or `write` is asserted. `address`, `writedata`, `byteenable` are held constant. The state exits to RESP at the edge where `waitrequest == 0`.
  - RESP: `resp_valid = 1` for exactly one cycle, then IDLE.
- Alignment rule: misaligned when half and `addr[0]`=1, when word and `addr[1:0]`≠0, or when size is 11. A misaligned request produces no bus cycle.
- `byteenable` values:
  - byte: `4'b0001 << addr[1:0]`.
  - half: `4'b0011 << addr[1:0]`.
  - word: `4'b1111`.
- `writedata` is `req_wdata` shifted left by 8·`addr[1:0]`. Unused lanes are 0. During reads `writedata` = 0.
- Read data:
  - `readdata` is captured at the completing edge and shifted right by 8·`addr[1:0]`.
  - It is then truncated to the access size.
  - Sign-extended if `req_signed`, else zero-extended.
- `read` and `write` are never asserted together and never asserted outside BUS.

## Timing
- Reset values:
  - State IDLE, so `req_ready` = 1.
  - `read`, `write`, `resp_valid`, `resp_err` = 0.
  - `address`, `writedata`, `byteenable`, `resp_rdata` = 0.
- Cycle sequence for an aligned request:
  - Accept edge E0.
  - `read`/`write` high in cycle E0+1.
  - If `waitrequest` is low at edge E1, `resp_valid` is high in cycle E1+1.
- Latency:
  - Minimum latency is 2 cycles from accept to `resp_valid`.
  - Each stalled `waitrequest` cycle adds 1.
- Misaligned request: `resp_valid` and `resp_err` are high in the cycle after accept.
- Back-to-back: a new request can be accepted in the cycle after `resp_valid` (IDLE). `req_valid` held high during BUS/RESP is ignored.
- Reset mid-transaction: at the reset edge the state goes to IDLE and `read`/`write` drop. No response is produced for the aborted access.
- All outputs are registered.

## Configuration
- Macro `MIPS_AVALON_MASTER_TIMEOUT_EN`.
- When defined:
  - A counter increments on every BUS cycle with `waitrequest` = 1.
  - When the counter reaches `TIMEOUT_CYCLES`, `read`/`write` drop at that edge.
  - The FSM then enters RESP with `resp_err` = 1 and `resp_rdata` = 0.
  - The counter clears on entry to BUS.
- When undefined: no counter is present, and BUS waits indefinitely on `waitrequest`.

## Test plan
- Store word:
  - Stimulus: store word 0xDEADBEEF to 0xBFC00004 with slave READ_DELAY=2.
  - Response: `address`=0xBFC00004, `byteenable`=1111, `writedata`=0xDEADBEEF, stable while `waitrequest` is high. Then a single `resp_valid` with `resp_err`=0.
- Store byte, then loads:
  - Stimulus: store byte 0x000000A5 to 0xBFC00007.
  - Required bus values: `address`=0xBFC00004, `byteenable`=1000, `writedata`=0xA5000000.
  - Signed load byte from 0xBFC00007 returns `resp_rdata`=0xFFFFFFA5. Unsigned load byte returns 0x000000A5.
- Half-word store and loads:
  - Stimulus: store half 0x00008001 to 0xBFC00002.
  - Required bus values: `byteenable`=1100, `writedata`=0x80010000.
  - Signed load half returns 0xFFFF8001. Unsigned load half returns 0x00008001.
- Misaligned load:
  - Stimulus: load half from 0xBFC00001.
  - Response: `read` is never asserted. `resp_valid`=`resp_err`=1 in the cycle after accept. `req_ready`=1 on the following cycle.
- Reset during stall:
  - Stimulus: assert `rst` while in BUS with `waitrequest` high.
  - Response: `read`=0 and `req_ready`=1 after the edge, and no `resp_valid` occurs.
- Timeout (macro defined, `TIMEOUT_CYCLES`=16):
  - Stimulus: hold `waitrequest` at 1.
  - Response: `read` drops after 16 stalled cycles, then `resp_valid`=1 with `resp_err`=1 and `resp_rdata`=0.
